// File: rtl/pll_lock_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : pll_lock_sequencer
// Brief    : Power-up / recovery sequencer for the TMDS PLL. Pulses PLL
//            RESET, waits for a synchronized and stable LOCK, then releases
//            the serializer reset followed by the pixel reset. Retries on
//            lock timeout and latches FAULT after MAX_RETRIES failures.
// Options  : `define PLL_SEQ_LOSS_CNT_EN adds an 8-bit saturating lock-loss
//            counter output (loss_cnt).
// Revision : 1.0 - initial release
// ============================================================================
module pll_lock_sequencer #(
  parameter int RST_CYCLES     = 16,
  parameter int LOCK_TIMEOUT   = 65535,
  parameter int STABLE_CYCLES  = 1024,
  parameter int STAGGER_CYCLES = 16,
  parameter int MAX_RETRIES    = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       lock_i,
  input  logic       force_reset,
  output logic       pll_reset,
  output logic       serdes_rst_n,
  output logic       pixel_rst_n,
  output logic       ready,
  output logic       fault,
  output logic [2:0] retry_cnt
`ifdef PLL_SEQ_LOSS_CNT_EN
  ,
  output logic [7:0] loss_cnt
`endif
);

  // Counter is sized for the longest of the four timed windows
  localparam int c_max_ab = (RST_CYCLES > LOCK_TIMEOUT) ? RST_CYCLES : LOCK_TIMEOUT;
  localparam int c_max_cd = (STABLE_CYCLES > STAGGER_CYCLES) ? STABLE_CYCLES : STAGGER_CYCLES;
  localparam int c_max    = (c_max_ab > c_max_cd) ? c_max_ab : c_max_cd;
  localparam int c_cnt_w  = $clog2(c_max) + 1;

  localparam logic [c_cnt_w-1:0] c_rst_last     = c_cnt_w'(RST_CYCLES - 1);
  localparam logic [c_cnt_w-1:0] c_timeout_last = c_cnt_w'(LOCK_TIMEOUT - 1);
  localparam logic [c_cnt_w-1:0] c_stable_last  = c_cnt_w'(STABLE_CYCLES - 1);
  localparam logic [c_cnt_w-1:0] c_stagger_last = c_cnt_w'(STAGGER_CYCLES - 1);
  localparam logic [2:0]         c_max_retries  = 3'(MAX_RETRIES);

  typedef enum logic [2:0] {
    ST_PLL_RST   = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_STABLE    = 3'd2,
    ST_SER_REL   = 3'd3,
    ST_RUN       = 3'd4,
    ST_FAULT     = 3'd5
  } state_t;

  state_t             state_q, state_d;
  logic [c_cnt_w-1:0] cnt_q, cnt_d;
  logic [2:0]         retry_q, retry_d;
  logic [2:0]         retry_inc;
  logic               lock_meta_q, lock_meta_d;
  logic               lock_s_q, lock_s_d;
  logic               pll_reset_q, pll_reset_d;
  logic               serdes_rst_n_q, serdes_rst_n_d;
  logic               pixel_rst_n_q, pixel_rst_n_d;
  logic               ready_q, ready_d;
  logic               fault_q, fault_d;

  // Two-stage synchronizer inputs for the asynchronous PLL LOCK
  always_comb begin
    lock_meta_d = lock_i;
    lock_s_d    = lock_meta_q;
  end

  // Synchronizer flops; cleared so lock is never assumed out of reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lock_meta_q <= 1'b0;
      lock_s_q    <= 1'b0;
    end else begin
      lock_meta_q <= lock_meta_d;
      lock_s_q    <= lock_s_d;
    end
  end

  // Next-state, shared counter, retry count and next-state-decoded outputs
  always_comb begin
    state_d   = state_q;
    retry_d   = retry_q;
    retry_inc = retry_q + 3'd1;

    if (force_reset) begin
      state_d = ST_PLL_RST;
      retry_d = 3'd0;
    end else begin
      case (state_q)
        ST_PLL_RST: begin
          if (cnt_q == c_rst_last) state_d = ST_WAIT_LOCK;
        end
        ST_WAIT_LOCK: begin
          if (lock_s_q) begin
            state_d = ST_STABLE;
          end else if (cnt_q == c_timeout_last) begin
            retry_d = retry_inc;
            state_d = (retry_inc == c_max_retries) ? ST_FAULT : ST_PLL_RST;
          end
        end
        ST_STABLE: begin
          // Any sampled low restarts the lock wait (and thus the window)
          if (!lock_s_q)                  state_d = ST_WAIT_LOCK;
          else if (cnt_q == c_stable_last) state_d = ST_SER_REL;
        end
        ST_SER_REL: begin
          if (!lock_s_q) begin
            state_d = ST_PLL_RST;
          end else if (cnt_q == c_stagger_last) begin
            state_d = ST_RUN;
            retry_d = 3'd0;
          end
        end
        ST_RUN: begin
          if (!lock_s_q) state_d = ST_PLL_RST;
        end
        ST_FAULT: begin
          state_d = ST_FAULT;
        end
        default: begin
          state_d = ST_PLL_RST;
        end
      endcase
    end

    // Counter clears on every transition (force into PLL_RST included)
    if (force_reset || (state_d != state_q)) begin
      cnt_d = '0;
    end else if ((state_q == ST_RUN) || (state_q == ST_FAULT)) begin
      cnt_d = cnt_q;
    end else begin
      cnt_d = cnt_q + c_cnt_w'(1);
    end

    // Outputs follow next-state so they change on the transition edge
    pll_reset_d    = (state_d == ST_PLL_RST) || (state_d == ST_FAULT);
    serdes_rst_n_d = (state_d == ST_SER_REL) || (state_d == ST_RUN);
    pixel_rst_n_d  = (state_d == ST_RUN);
    ready_d        = (state_d == ST_RUN);
    fault_d        = (state_d == ST_FAULT);
  end

  // State, counter, retry and registered output flops
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ST_PLL_RST;
      cnt_q          <= '0;
      retry_q        <= 3'd0;
      pll_reset_q    <= 1'b1;
      serdes_rst_n_q <= 1'b0;
      pixel_rst_n_q  <= 1'b0;
      ready_q        <= 1'b0;
      fault_q        <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      retry_q        <= retry_d;
      pll_reset_q    <= pll_reset_d;
      serdes_rst_n_q <= serdes_rst_n_d;
      pixel_rst_n_q  <= pixel_rst_n_d;
      ready_q        <= ready_d;
      fault_q        <= fault_d;
    end
  end

  assign pll_reset    = pll_reset_q;
  assign serdes_rst_n = serdes_rst_n_q;
  assign pixel_rst_n  = pixel_rst_n_q;
  assign ready        = ready_q;
  assign fault        = fault_q;
  assign retry_cnt    = retry_q;

`ifdef PLL_SEQ_LOSS_CNT_EN
  logic       lock_lost;
  logic [7:0] loss_cnt_q, loss_cnt_d;

  // Lock loss from a released state; a simultaneous force_reset takes precedence
  assign lock_lost = !force_reset && !lock_s_q &&
                     ((state_q == ST_SER_REL) || (state_q == ST_RUN));

  // Saturating lock-loss event counter
  always_comb begin
    loss_cnt_d = loss_cnt_q;
    if (lock_lost && (loss_cnt_q != 8'hFF)) loss_cnt_d = loss_cnt_q + 8'd1;
  end

  // Loss counter flop; only rst_n clears it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) loss_cnt_q <= 8'd0;
    else        loss_cnt_q <= loss_cnt_d;
  end

  assign loss_cnt = loss_cnt_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pll_lock_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_pll_lock_sequencer
// Brief    : Directed self-checking bench for pll_lock_sequencer using small
//            parameters; expected values are hand-derived cycle positions.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pll_lock_sequencer;

  localparam int RST_CYCLES     = 4;
  localparam int LOCK_TIMEOUT   = 32;
  localparam int STABLE_CYCLES  = 8;
  localparam int STAGGER_CYCLES = 4;
  localparam int MAX_RETRIES    = 2;

  // Output vector {pll_reset, serdes_rst_n, pixel_rst_n, ready, fault}
  localparam logic [4:0] O_PLL_RST = 5'b10000;
  localparam logic [4:0] O_WAITING = 5'b00000;
  localparam logic [4:0] O_SER_REL = 5'b01000;
  localparam logic [4:0] O_RUN     = 5'b01110;
  localparam logic [4:0] O_FAULT   = 5'b10001;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       lock_i;
  logic       force_reset;
  logic       pll_reset;
  logic       serdes_rst_n;
  logic       pixel_rst_n;
  logic       ready;
  logic       fault;
  logic [2:0] retry_cnt;
`ifdef PLL_SEQ_LOSS_CNT_EN
  logic [7:0] loss_cnt;
`endif
  logic [4:0] outs;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  pll_lock_sequencer #(
    .RST_CYCLES     (RST_CYCLES),
    .LOCK_TIMEOUT   (LOCK_TIMEOUT),
    .STABLE_CYCLES  (STABLE_CYCLES),
    .STAGGER_CYCLES (STAGGER_CYCLES),
    .MAX_RETRIES    (MAX_RETRIES)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .lock_i       (lock_i),
    .force_reset  (force_reset),
    .pll_reset    (pll_reset),
    .serdes_rst_n (serdes_rst_n),
    .pixel_rst_n  (pixel_rst_n),
    .ready        (ready),
    .fault        (fault),
    .retry_cnt    (retry_cnt)
`ifdef PLL_SEQ_LOSS_CNT_EN
    ,
    .loss_cnt     (loss_cnt)
`endif
  );

  assign outs = {pll_reset, serdes_rst_n, pixel_rst_n, ready, fault};

  task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance n rising edges, then settle 1 time unit past the last edge
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Pixel domain must never be out of reset while the serializer is held
  always @(negedge clk) begin
    if (rst_n === 1'b1) check_eq("order", 8'(pixel_rst_n & ~serdes_rst_n), 8'd0);
  end

  initial begin
    rst_n       = 1'b0;
    lock_i      = 1'b0;
    force_reset = 1'b0;

    // ---- Reset state ----
    step(3);
    check_eq("rst_outs", 8'(outs), 8'(O_PLL_RST));
    check_eq("rst_retry", 8'(retry_cnt), 8'd0);

    // ---- Scenario 1: normal bring-up ----
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(1);
      check_eq("s1_pllrst_hi", 8'(outs), 8'(O_PLL_RST));
    end
    step(1);
    check_eq("s1_pllrst_lo", 8'(outs), 8'(O_WAITING));
    lock_i = 1'b1;
    step(10);
    check_eq("s1_pre_serdes", 8'(outs), 8'(O_WAITING));
    step(1);
    check_eq("s1_serdes_up", 8'(outs), 8'(O_SER_REL));
    step(3);
    check_eq("s1_pre_pixel", 8'(outs), 8'(O_SER_REL));
    step(1);
    check_eq("s1_run", 8'(outs), 8'(O_RUN));
    check_eq("s1_retry", 8'(retry_cnt), 8'd0);

    // ---- Scenario 4: lock loss from RUN ----
    lock_i = 1'b0;
    step(2);
    check_eq("s4_still_run", 8'(outs), 8'(O_RUN));
    step(1);
    check_eq("s4_dropped", 8'(outs), 8'(O_PLL_RST));
    check_eq("s4_retry", 8'(retry_cnt), 8'd0);
`ifdef PLL_SEQ_LOSS_CNT_EN
    check_eq("s4_loss_cnt", loss_cnt, 8'd1);
`endif
    lock_i = 1'b1;
    step(3);
    check_eq("s4_pllrst_hi", 8'(outs), 8'(O_PLL_RST));
    step(1);
    check_eq("s4_wait", 8'(outs), 8'(O_WAITING));
    step(8);
    check_eq("s4_stable", 8'(outs), 8'(O_WAITING));
    step(1);
    check_eq("s4_serdes_up", 8'(outs), 8'(O_SER_REL));
    step(3);
    check_eq("s4_pre_pixel", 8'(outs), 8'(O_SER_REL));
    step(1);
    check_eq("s4_run_again", 8'(outs), 8'(O_RUN));

    // ---- Scenario 3: one-cycle lock glitch in STABLE at count 5 ----
    rst_n = 1'b0;
    step(2);
    rst_n = 1'b1;
    step(8);
    lock_i = 1'b0;
    step(1);
    lock_i = 1'b1;
    step(4);
    check_eq("s3_no_orig_rel", 8'(outs), 8'(O_WAITING));
    step(6);
    check_eq("s3_pre_rel", 8'(outs), 8'(O_WAITING));
    step(1);
    check_eq("s3_serdes_up", 8'(outs), 8'(O_SER_REL));
    check_eq("s3_retry", 8'(retry_cnt), 8'd0);

    // ---- Scenario 6: asynchronous reset mid SER_REL ----
    step(1);
    rst_n = 1'b0;
    #2;
    check_eq("s6_async_outs", 8'(outs), 8'(O_PLL_RST));
    check_eq("s6_async_retry", 8'(retry_cnt), 8'd0);

    // ---- Scenario 2: lock never arrives -> FAULT, then force_reset ----
    lock_i = 1'b0;
    step(2);
    rst_n = 1'b1;
    step(4);
    check_eq("s2_wait1", 8'(outs), 8'(O_WAITING));
    step(31);
    check_eq("s2_pre_to1", 8'(outs), 8'(O_WAITING));
    check_eq("s2_retry0", 8'(retry_cnt), 8'd0);
    step(1);
    check_eq("s2_to1_outs", 8'(outs), 8'(O_PLL_RST));
    check_eq("s2_retry1", 8'(retry_cnt), 8'd1);
    step(3);
    check_eq("s2_pulse2_hi", 8'(outs), 8'(O_PLL_RST));
    step(1);
    check_eq("s2_wait2", 8'(outs), 8'(O_WAITING));
    step(31);
    check_eq("s2_pre_to2", 8'(outs), 8'(O_WAITING));
    step(1);
    check_eq("s2_fault", 8'(outs), 8'(O_FAULT));
    check_eq("s2_retry2", 8'(retry_cnt), 8'd2);
    step(5);
    check_eq("s2_fault_held", 8'(outs), 8'(O_FAULT));
    force_reset = 1'b1;
    step(1);
    force_reset = 1'b0;
    check_eq("s2_forced", 8'(outs), 8'(O_PLL_RST));
    check_eq("s2_forced_retry", 8'(retry_cnt), 8'd0);
    step(3);
    check_eq("s2_new_rst_hi", 8'(outs), 8'(O_PLL_RST));
    step(1);
    check_eq("s2_new_rst_lo", 8'(outs), 8'(O_WAITING));

    // ---- Scenario 5: force_reset coincides with second timeout ----
    step(31);
    check_eq("s5_pre_to1", 8'(outs), 8'(O_WAITING));
    step(1);
    check_eq("s5_retry1", 8'(retry_cnt), 8'd1);
    step(4);
    check_eq("s5_wait2", 8'(outs), 8'(O_WAITING));
    step(31);
    force_reset = 1'b1;
    step(1);
    force_reset = 1'b0;
    check_eq("s5_forced", 8'(outs), 8'(O_PLL_RST));
    check_eq("s5_retry0", 8'(retry_cnt), 8'd0);
    step(4);
    check_eq("s5_no_fault", 8'(outs), 8'(O_WAITING));
    check_eq("s5_retry_still0", 8'(retry_cnt), 8'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
